// File: rtl/mul4_seq_ctrl_pkg.sv
// ============================================================================
// Module      : mul4_seq_ctrl_pkg
// Description : Shared widths, FSM state type and step helpers for mul4_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul4_seq_ctrl_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Left shift 2*(i+j) applied to the partial product of each step.
    function automatic logic [2:0] pp_shift(input state_t s);
        case (s)
            S_PP1, S_PP2: pp_shift = 3'd2;
            S_PP3:        pp_shift = 3'd4;
            default:      pp_shift = 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul4_seq_ctrl_pp2x2.sv
// ============================================================================
// Module      : pp2x2
// Description : Combinational 2x2 -> 4-bit multiplier from AND gates and half adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp2x2 (
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    output logic [3:0] o_p
);

    logic w_x0y0;
    logic w_x1y0;
    logic w_x0y1;
    logic w_x1y1;
    logic w_c1;

    assign w_x0y0 = i_x[0] & i_y[0];
    assign w_x1y0 = i_x[1] & i_y[0];
    assign w_x0y1 = i_x[0] & i_y[1];
    assign w_x1y1 = i_x[1] & i_y[1];

    // Two half adders ripple the middle column carry into the top bits.
    assign w_c1   = w_x1y0 & w_x0y1;
    assign o_p[0] = w_x0y0;
    assign o_p[1] = w_x1y0 ^ w_x0y1;
    assign o_p[2] = w_x1y1 ^ w_c1;
    assign o_p[3] = w_x1y1 & w_c1;

endmodule

`default_nettype wire

// File: rtl/mul4_seq_ctrl.sv
// ============================================================================
// Module      : mul4_seq_ctrl
// Description : Handshaked 4x4 multiplier sharing one 2x2 unit over four steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul4_seq_ctrl
    import mul4_seq_ctrl_pkg::*;
#(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [PROD_W-1:0] o_p,
    output logic              o_busy
);

    state_t              r_state;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [PROD_W-1:0]   r_acc;
    logic                r_out_valid;
    logic                r_busy;

    logic                w_accept;
    logic                w_zero_op;
    logic [1:0]          w_a_half;
    logic [1:0]          w_b_half;
    logic [3:0]          w_pp;
    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_sum;

    assign o_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_zero_op  = (i_a == '0) || (i_b == '0);

    // Step order: PP0=(lo,lo), PP1=(hi,lo), PP2=(lo,hi), PP3=(hi,hi).
    always_comb begin
        w_a_half = r_a[1:0];
        w_b_half = r_b[1:0];
        case (r_state)
            S_PP1: w_a_half = r_a[3:2];
            S_PP2: w_b_half = r_b[3:2];
            S_PP3: begin
                w_a_half = r_a[3:2];
                w_b_half = r_b[3:2];
            end
            default: ;
        endcase
    end

    pp2x2 u_pp2x2 (
        .i_x (w_a_half),
        .i_y (w_b_half),
        .o_p (w_pp)
    );

    assign w_addend = {4'b0000, w_pp} << pp_shift(r_state);
    assign w_sum    = r_acc + w_addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Accept only occurs in IDLE or in DONE while the old result pops.
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
            r_busy <= 1'b1;
            if (EARLY_ZERO && w_zero_op) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= S_PP0;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_PP0: begin
                    r_acc   <= w_sum;
                    r_state <= S_PP1;
                end
                S_PP1: begin
                    r_acc   <= w_sum;
                    r_state <= S_PP2;
                end
                S_PP2: begin
                    r_acc   <= w_sum;
                    r_state <= S_PP3;
                end
                S_PP3: begin
                    r_acc       <= w_sum;
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                S_IDLE: ;
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_p         = r_acc;
    assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mul4_seq_ctrl.sv
// ============================================================================
// Module      : tb_mul4_seq_ctrl
// Description : Self-checking bench for mul4_seq_ctrl (both EARLY_ZERO settings).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] a, b;
    logic [7:0] p;

    logic       z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic [3:0] z_a, z_b;
    logic [7:0] z_p;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul4_seq_ctrl #(.EARLY_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_p         (p),
        .o_busy      (busy)
    );

    mul4_seq_ctrl #(.EARLY_ZERO(1'b0)) dut_nz (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (z_in_valid),
        .o_in_ready  (z_in_ready),
        .i_a         (z_a),
        .i_b         (z_b),
        .o_out_valid (z_out_valid),
        .i_out_ready (z_out_ready),
        .o_p         (z_p),
        .o_busy      (z_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = edges after the accepting edge until out_valid is visible.
    task automatic run_one(input logic [3:0] ta, input logic [3:0] tb_,
                           input logic [7:0] ep, input int ek, input string nm);
        int  k;
        bit  rdy_bad;
        k = 0;
        while (!in_ready && k < 50) begin step(); k++; end
        chk({nm, " in_ready before accept"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        chk({nm, " busy after accept"}, busy, 1);
        k       = 0;
        rdy_bad = 1'b0;
        while (!out_valid && k < 20) begin
            if (in_ready) rdy_bad = 1'b1;
            step();
            k++;
        end
        chk({nm, " latency"}, k, ek);
        chk({nm, " product"}, p, ep);
        chk({nm, " in_ready low while computing"}, rdy_bad, 0);
        step();
        chk({nm, " out_valid after pop"}, out_valid, 0);
        chk({nm, " busy after pop"}, busy, 0);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         k;
    } vec_t;

    vec_t vt[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         k, idx, npop;
        bit         flag;
        logic [7:0] hold_p;
        logic [7:0] bb_a[3];
        logic [7:0] bb_b[3];
        logic [7:0] pop_p[$];
        int         pop_c[$];
        logic [7:0] order[256];
        logic [7:0] exp_q[$];
        logic [7:0] tmp;
        logic [7:0] prev_p;
        bit         prev_stall, acc, pop;

        // Zero operands complete on the accepting edge itself when EARLY_ZERO=1.
        vt[0] = '{4'd15, 4'd15, 8'd225, 4};
        vt[1] = '{4'd0,  4'd9,  8'd0,   0};
        vt[2] = '{4'd7,  4'd0,  8'd0,   0};
        vt[3] = '{4'd1,  4'd1,  8'd1,   4};
        vt[4] = '{4'd10, 4'd5,  8'd50,  4};
        vt[5] = '{4'd3,  4'd13, 8'd39,  4};
        vt[6] = '{4'd8,  4'd8,  8'd64,  4};
        vt[7] = '{4'd15, 4'd1,  8'd15,  4};

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0;
        z_in_valid = 0; z_out_ready = 0; z_a = 0; z_b = 0;
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset p", p, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            run_one(vt[i].a, vt[i].b, vt[i].p, vt[i].k, $sformatf("vec%0d", i));

        // Zero operand without early exit still walks all four steps.
        z_in_valid = 1'b1; z_a = 4'd0; z_b = 4'd9; z_out_ready = 1'b1;
        step();
        z_in_valid = 1'b0;
        k = 0;
        while (!z_out_valid && k < 20) begin step(); k++; end
        chk("nz latency", k, 4);
        chk("nz product", z_p, 0);
        z_out_ready = 1'b0;

        // Back-pressure: hold (6,7) for 10 cycles.
        in_valid = 1'b1; a = 4'd6; b = 4'd7; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin step(); k++; end
        chk("hold latency", k, 4);
        chk("hold product", p, 42);
        hold_p = p;
        flag   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || p !== hold_p || in_ready) flag = 1'b1;
            step();
        end
        chk("hold stable", flag, 0);
        out_ready = 1'b1;
        #1;
        chk("hold in_ready on pop", in_ready, 1);
        step();
        chk("hold popped", out_valid, 0);
        out_ready = 1'b0;

        // Back-to-back stream with overlapping pop and accept.
        bb_a = '{8'd3, 8'd12, 8'd9};
        bb_b = '{8'd5, 8'd11, 8'd9};
        idx = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        a = bb_a[0][3:0]; b = bb_b[0][3:0];
        for (int cyc = 0; cyc < 60 && pop_p.size() < 3; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin pop_p.push_back(p); pop_c.push_back(cyc); end
            step();
            if (acc) begin
                idx++;
                if (idx < 3) begin a = bb_a[idx][3:0]; b = bb_b[idx][3:0]; end
                else in_valid = 1'b0;
            end
        end
        chk("b2b count", pop_p.size(), 3);
        if (pop_p.size() == 3) begin
            chk("b2b p0", pop_p[0], 15);
            chk("b2b p1", pop_p[1], 132);
            chk("b2b p2", pop_p[2], 81);
            chk("b2b spacing01", pop_c[1] - pop_c[0], 5);
            chk("b2b spacing12", pop_c[2] - pop_c[1], 5);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;

        // Reset during PP2 of (13,14); lo*lo=2 plus (hi*lo)<<2=24 so far.
        in_valid = 1'b1; a = 4'd13; b = 4'd14;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid partial sum", p, 26);
        rst_n = 1'b0;
        #1;
        chk("mid-reset out_valid", out_valid, 0);
        chk("mid-reset busy", busy, 0);
        chk("mid-reset in_ready", in_ready, 1);
        chk("mid-reset p", p, 0);
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid) flag = 1'b1;
        end
        chk("mid-reset no out_valid", flag, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        run_one(4'd2, 4'd3, 8'd6, 4, "post-reset");

        // All 256 pairs, shuffled, with random valid gaps and consumer stalls.
        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            k = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[k]; order[k] = tmp;
        end
        idx = 0; npop = 0; flag = 1'b0; prev_stall = 1'b0; prev_p = '0;
        for (int cyc = 0; cyc < 30000 && npop < 256; cyc++) begin
            if (idx < 256) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = order[idx][7:4];
                b = order[idx][3:0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall && (!out_valid || p !== prev_p)) flag = 1'b1;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (exp_q.size() == 0) chk("rnd unexpected product", 1, 0);
                else chk($sformatf("rnd product #%0d", npop), p, exp_q.pop_front());
                npop++;
            end
            if (acc) begin
                exp_q.push_back(8'(int'(a) * int'(b)));
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = p;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("rnd products delivered", npop, 256);
        chk("rnd leftover expected", exp_q.size(), 0);
        chk("rnd stall hold", flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
